sub_bytes_seq: RTL and testbench

SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

---
 rtl/sub_bytes_seq.sv | 195 +++++++++++++++++++
 tb/tb_sub_bytes_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes / InvSubBytes over a 128-bit state, LANES bytes per clock.

// GF(2^8) multiplicative inverse (0 maps to 0), computed as a^254.
module sub_bytes_seq_gf_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] acc;

  // a^254 = a^2 * a^4 * ... * a^128 via repeated squaring.
  always_comb begin
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    y = acc;
  end

endmodule

// Forward S-box: field inverse followed by the affine map.
module sub_bytes_seq_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] v;

  sub_bytes_seq_gf_inv u_inv (
    .a (a),
    .y (v)
  );

  // Affine transform: v ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
               ^ {v[3:0], v[7:4]} ^ 8'h63;

endmodule

// Inverse S-box: inverse affine map followed by the field inverse.
module sub_bytes_seq_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] u;

  // Inverse affine transform: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  assign u = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

  sub_bytes_seq_gf_inv u_inv (
    .a (u),
    .y (y)
  );

endmodule

module sub_bytes_seq #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned NBYTES  = 16;
  localparam int unsigned NCHUNK  = NBYTES / LANES;
  localparam int unsigned CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CHUNK_W = LANES * 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  // Reject unsupported lane counts and state widths at elaboration.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  if (DATA_W != 128) begin : g_bad_width
    $error("sub_bytes_seq: DATA_W must be 128");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             st_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  state_q;
  logic               mode_q;
  logic [6:0]         base_c;
  logic [CHUNK_W-1:0] chunk_in;
  logic [CHUNK_W-1:0] chunk_out;

  // Bit offset of the chunk currently being substituted.
  assign base_c   = 7'(32'(cnt_q) * CHUNK_W);
  assign chunk_in = state_q[base_c +: CHUNK_W];

  // One forward and one inverse S-box per lane, selected by the latched mode.
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    logic [7:0] fwd;
    logic [7:0] inv;

    sub_bytes_seq_sbox u_sbox (
      .a (chunk_in[8*l +: 8]),
      .y (fwd)
    );

    sub_bytes_seq_inv_sbox u_inv_sbox (
      .a (chunk_in[8*l +: 8]),
      .y (inv)
    );

    assign chunk_out[8*l +: 8] = mode_q ? inv : fwd;
  end

  // Control FSM with registered handshake outputs and the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      state_q   <= '0;
      mode_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= in_data;
            mode_q   <= in_inv;
            cnt_q    <= '0;
            st_q     <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          state_q[base_c +: CHUNK_W] <= chunk_out;
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            st_q      <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q      <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          st_q      <= IDLE;
          cnt_q     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // The result is the state register itself; it is stable throughout DONE.
  assign out_data = state_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Testbench for sub_bytes_seq: known-answer table, random model checks, corner sequences.
`timescale 1ns/1ps

module tb_sub_bytes_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks;
  int passed;

  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];

  sub_bytes_seq #(.LANES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] r;
    inv = 8'h00;
    c   = 8'h63;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return r;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int j = 0; j < 16; j++)
      r[8*j +: 8] = inv ? isbox_t[d[8*j +: 8]] : sbox_t[d[8*j +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) sbox_t[x] = sbox_ref(8'(x));
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
  end

  // ---------------- main DUT helpers ----------------
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_one(input logic [127:0] d, input logic inv, input logic [127:0] exp, input string nm);
    int lat;
    chk(in_ready == 1'b1, {nm, " in_ready idle"}, 128'(in_ready), 128'd1);
    in_data = d; in_inv = inv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(busy == 1'b1 && in_ready == 1'b0, {nm, " busy/in_ready after accept"},
        {busy, in_ready}, 128'b10);
    wait_out(lat);
    chk(lat == 4, {nm, " latency"}, 128'(lat), 128'd4);
    chk(out_data == exp, {nm, " data"}, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(in_ready == 1'b1 && out_valid == 1'b0, {nm, " retire"}, {in_ready, out_valid}, 128'b10);
  endtask

  typedef struct {
    logic [127:0] data;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  // ---------------- other lane counts: forward/inverse round trip ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
    localparam int unsigned LP = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
    logic         rn, iv, ir, ii, ov, ordy, bz;
    logic [127:0] id, od;
    logic         done_g;

    sub_bytes_seq #(.LANES(LP)) u_dut (
      .clk       (clk),
      .rst_n     (rn),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .in_inv    (ii),
      .out_valid (ov),
      .out_ready (ordy),
      .out_data  (od),
      .busy      (bz)
    );

    initial begin
      logic [127:0] d;
      logic [127:0] f;
      logic [127:0] e;
      int lat;
      done_g = 1'b0;
      rn = 1'b0; iv = 1'b0; ii = 1'b0; id = '0; ordy = 1'b0; f = '0;
      repeat (3) @(posedge clk);
      #1 rn = 1'b1;
      for (int t = 0; t < 4; t++) begin
        d = rand128();
        for (int pass = 0; pass < 2; pass++) begin
          id = (pass == 0) ? d : f;
          ii = 1'(pass);
          e  = (pass == 0) ? sub_ref(d, 1'b0) : d;
          iv = 1'b1;
          @(posedge clk); #1;
          iv = 1'b0;
          lat = 0;
          while (!ov && lat < 64) begin
            @(posedge clk); #1;
            lat++;
          end
          chk(lat == int'(16 / LP), $sformatf("L%0d latency pass%0d", LP, pass), 128'(lat), 128'(16 / LP));
          chk(od == e, $sformatf("L%0d data pass%0d", LP, pass), od, e);
          if (pass == 0) f = od;
          ordy = 1'b1;
          @(posedge clk); #1;
          ordy = 1'b0;
        end
      end
      done_g = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs [6];
    logic [127:0] d, e, snap;
    logic m;
    int lat;
    bit ok_a, ok_b;

    checks = 0; passed = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;

    vecs[0] = '{128'h0, 1'b0, {16{8'h63}}};
    vecs[1] = '{{16{8'h63}}, 1'b1, 128'h0};
    vecs[2] = '{{{15{8'h63}}, 8'hED}, 1'b1, 128'h53};
    vecs[3] = '{128'h53, 1'b0, {{15{8'h63}}, 8'hED}};
    vecs[4] = '{128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63};
    vecs[5] = '{128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100};

    repeat (3) @(posedge clk);
    #1;
    chk(in_ready == 1'b1 && out_valid == 1'b0 && busy == 1'b0, "reset handshake",
        {in_ready, out_valid, busy}, 128'b100);
    chk(out_data == 128'h0, "reset out_data", out_data, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_one(vecs[i].data, vecs[i].inv, vecs[i].exp, $sformatf("kat%0d", i));

    for (int i = 0; i < 10; i++) begin
      d = rand128();
      m = 1'($urandom_range(0, 1));
      run_one(d, m, sub_ref(d, m), $sformatf("rand%0d", i));
    end

    // Backpressure: result held while out_ready is low, new inputs ignored.
    d = rand128();
    in_data = d; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk(lat == 4, "bp latency", 128'(lat), 128'd4);
    snap = out_data;
    chk(snap == sub_ref(d, 1'b0), "bp data", snap, sub_ref(d, 1'b0));
    in_valid = 1'b1; in_data = ~d; in_inv = 1'b1;
    ok_a = 1'b1; ok_b = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_data != snap || !out_valid) ok_a = 1'b0;
      if (in_ready != 1'b0) ok_b = 1'b0;
    end
    chk(ok_a, "bp out stable", out_data, snap);
    chk(ok_b, "bp in_ready low", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(in_ready == 1'b1 && busy == 1'b0, "bp release", {in_ready, busy}, 128'b10);
    chk(out_data == snap, "bp nothing captured", out_data, snap);

    // Inputs and out_ready toggled while BUSY must not disturb the result.
    d = rand128();
    in_data = d; in_inv = 1'b1; in_valid = 1'b1;
    e = sub_ref(d, 1'b1);
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 64) begin
      in_data = rand128(); in_inv = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk(lat == 4, "toggle latency", 128'(lat), 128'd4);
    chk(out_data == e, "toggle data", out_data, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of BUSY (cnt = 2).
    in_data = rand128(); in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk(in_ready == 1'b1 && out_valid == 1'b0 && busy == 1'b0, "midbusy reset handshake",
        {in_ready, out_valid, busy}, 128'b100);
    chk(out_data == 128'h0, "midbusy reset state", out_data, 128'h0);
    #2 rst_n = 1'b1;
    ok_a = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) ok_a = 1'b0;
    end
    chk(ok_a, "discarded result", {out_valid, busy}, 128'b0);
    d = rand128();
    run_one(d, 1'b0, sub_ref(d, 1'b0), "after reset");

    // Wait for the other lane-count benches.
    lat = 0;
    while (!(g_lanes[0].done_g && g_lanes[1].done_g && g_lanes[2].done_g && g_lanes[3].done_g)
           && lat < 5000) begin
      @(posedge clk);
      lat++;
    end
    chk(lat < 5000, "lane benches finished", 128'(lat), 128'd5000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
